// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner: per-digit slots with a blanked guard
// interval, frame-synchronised value updates, leading-zero suppression.
module display_scan_ctrl #(
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_mask_i,
  input  logic [3:0]  blank_mask_i,
  input  logic        lzs_i,
  output logic [3:0]  digit_hex_o,
  output logic [3:0]  an_n_o,
  output logic        dp_n_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        dbg_state_o
);

  localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_PRE = CNT_W'(GUARD_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // Handshake: load_i is a single-cycle strobe with no ready; it is always
  // accepted. busy_o is high while a captured value waits for the frame end.

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  state_e           state_q, state_d;
  logic [15:0]      active_value_q, active_value_d;
  logic [3:0]       active_dp_q, active_dp_d;
  logic [15:0]      pend_value_q, pend_value_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [3:0]       digit_hex_q, digit_hex_d;
  logic [3:0]       an_n_q, an_n_d;
  logic             dp_n_q, dp_n_d;

  logic       slot_wrap;
  logic       frame_end;
  logic [3:0] nib_zero;
  logic [3:0] lead_zero;
  logic       suppressed;
  logic       lit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q     <= '0;
      digit_idx_q    <= 2'd0;
      state_q        <= ST_BLANK;
      active_value_q <= 16'h0000;
      active_dp_q    <= 4'h0;
      pend_value_q   <= 16'h0000;
      pend_dp_q      <= 4'h0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      digit_hex_q    <= 4'h0;
      an_n_q         <= 4'hF;
      dp_n_q         <= 1'b1;
    end else begin
      slot_cnt_q     <= slot_cnt_d;
      digit_idx_q    <= digit_idx_d;
      state_q        <= state_d;
      active_value_q <= active_value_d;
      active_dp_q    <= active_dp_d;
      pend_value_q   <= pend_value_d;
      pend_dp_q      <= pend_dp_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      digit_hex_q    <= digit_hex_d;
      an_n_q         <= an_n_d;
      dp_n_q         <= dp_n_d;
    end
  end

  // Slot and digit counters.
  always_comb begin
    slot_wrap   = (slot_cnt_q == SLOT_LAST);
    frame_end   = slot_wrap && (digit_idx_q == 2'd3);
    slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
    digit_idx_d = slot_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
  end

  // state_q tracks slot_cnt_q: SHOW exactly when slot_cnt_q >= GUARD_CYCLES.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (slot_cnt_q == GUARD_PRE) state_d = ST_SHOW;
      ST_SHOW:  if (slot_wrap)               state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // A load on the boundary cycle bypasses pending and wins over it.
  always_comb begin
    active_value_d = active_value_q;
    active_dp_d    = active_dp_q;
    pend_value_d   = pend_value_q;
    pend_dp_d      = pend_dp_q;
    busy_d         = busy_q;
    if (frame_end) begin
      if (load_i) begin
        active_value_d = value_i;
        active_dp_d    = dp_mask_i;
      end else if (busy_q) begin
        active_value_d = pend_value_q;
        active_dp_d    = pend_dp_q;
      end
      busy_d = 1'b0;
    end else if (load_i) begin
      pend_value_d = value_i;
      pend_dp_d    = dp_mask_i;
      busy_d       = 1'b1;
    end
  end

  // Output staging from the current counter/state snapshot.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nib_zero[i] = (active_value_q[4*i +: 4] == 4'h0);
    end
    lead_zero[3] = nib_zero[3];
    lead_zero[2] = nib_zero[2] & lead_zero[3];
    lead_zero[1] = nib_zero[1] & lead_zero[2];
    lead_zero[0] = 1'b0;

    suppressed   = blank_mask_i[digit_idx_q] | (lzs_i & lead_zero[digit_idx_q]);
    lit          = (state_q == ST_SHOW) && !suppressed;

    digit_hex_d  = active_value_q[{digit_idx_q, 2'b00} +: 4];
    an_n_d       = lit ? ~(4'b0001 << digit_idx_q) : 4'hF;
    dp_n_d       = !(lit && active_dp_q[digit_idx_q]);
    frame_done_d = frame_end;
  end

  assign digit_hex_o  = digit_hex_q;
  assign an_n_o       = an_n_q;
  assign dp_n_o       = dp_n_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign dbg_state_o  = state_q;

endmodule
